ram_2port_be_clr: RTL and testbench
===================================

Name: ram_2port_be_clr

Overview:
Single-clock simple dual-port RAM: one write port and one read port. It is the parametrised successor of the team's basic two-port RAM and adds per-byte write enables, selectable read latency, a defined read-during-write policy, and a hardware clear sequencer. The clear sequencer zeroes the whole array after reset and on request. It is used as the generic buffer/lookup store under FIFOs and packet buffers.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of 8 and at least 8.
DEPTH, 16, number of words; at least 2; need not be a power of 2.
RD_LATENCY, 1, cycles from accepted read to o_Rd_DV; legal values are 1 or 2 (2 adds an output register).
RDW_MODE, 0, same-address read during write: 0 = return old data, 1 = return new data (byte-merged bypass).
CLEAR_VALUE, 0, WIDTH-bit value written to every word by the clear sequencer.

Ports:
i_Clk  in  1  single clock for both ports.
i_Rst_L  in  1  asynchronous, active-low reset.
i_Wr_Addr  in  $clog2(DEPTH)  write address.
i_Wr_DV  in  1  write strobe.
i_Wr_Data  in  WIDTH  write data.
i_Wr_Be  in  WIDTH/8  byte enables; bit n covers data bits [8n+7:8n].
i_Rd_Addr  in  $clog2(DEPTH)  read address.
i_Rd_En  in  1  read request.
o_Rd_DV  out  1  read data valid, one-cycle pulse per accepted read.
o_Rd_Data  out  WIDTH  read data.
i_Clear  in  1  request a full-array clear; level-sampled.
o_Busy  out  1  high while the clear sequencer owns the array.

Behaviour:
- Reset (i_Rst_L=0), asynchronous:
  - Outputs go to o_Rd_DV=0, o_Rd_Data=0, o_Busy=1.
  - FSM goes to CLEAR with clear address = 0.
  - The read pipeline is flushed.
  - Array contents are not reset directly; the clear sequence zeroes them.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes CLEAR_VALUE to the clear address and increments it.
  - CLEAR exits to IDLE on the cycle the write to address DEPTH-1 occurs. CLEAR lasts exactly DEPTH cycles after reset release.
  - IDLE: if i_Clear=1, go to CLEAR with address 0; o_Busy rises on the next cycle.
  - i_Clear asserted while already in CLEAR is ignored; the sequence does not restart.
  - A reset mid-clear restarts the sequence from address 0.
- o_Busy = 1 exactly while the FSM is in CLEAR. In CLEAR:
  - i_Wr_DV is ignored.
  - i_Rd_En is ignored: no o_Rd_DV is produced.
  - Reads already in flight when CLEAR is entered still complete, carrying pre-clear data.
- Write (IDLE, i_Wr_DV=1): on the rising edge, for each n with i_Wr_Be[n]=1, mem[i_Wr_Addr] byte n takes i_Wr_Data byte n. Other bytes are unchanged. i_Wr_Be = 0 writes nothing.
- Read (IDLE, i_Rd_En=1):
  - RD_LATENCY=1: o_Rd_Data and o_Rd_DV=1 are valid on the first edge after the request.
  - RD_LATENCY=2: valid one edge later.
  - Back-to-back reads are accepted every cycle: full throughput, no bubbles.
  - o_Rd_Data holds its last value when o_Rd_DV=0.
- Read during write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, with enabled bytes taken from i_Wr_Data and the rest from the old word.
  - Different addresses: the two ports are fully independent.
- Addresses >= DEPTH when DEPTH is not a power of 2:
  - Writes are dropped.
  - Reads return 0 with o_Rd_DV=1.

Test Plan:
1. WIDTH=16, DEPTH=4, release reset -> o_Busy=1 for exactly 4 cycles, then 0. Reading addresses 0..3 returns 0x0000 each, o_Rd_DV=1 one cycle after each request.
2. Write 0x1111,0x2222,0x3333,0x4444 to addresses 0..3 with Be=2'b11, then read back-to-back (RD_LATENCY=1 and 2) -> the same values, in order. o_Rd_DV high for 4 consecutive cycles, starting 1 (resp. 2) cycles after the first request.
3. mem[1]=0x2222, write 0xAB55 to address 1 with Be=2'b01 -> read returns 0x2255. Then Be=2'b10 with data 0xCD00 -> read returns 0xCD55.
4. mem[1]=0x2222, same-cycle write 0x0054 (Be=2'b11) and read of address 1 -> RDW_MODE=0 returns 0x2222; RDW_MODE=1 returns 0x0054. A read the following cycle returns 0x0054 in both modes.
5. In IDLE with data loaded, pulse i_Clear while also driving i_Wr_DV and i_Rd_En -> o_Busy high for 4 cycles; no o_Rd_DV for reads requested during busy; all words read 0x0000 afterwards.
6. Drop i_Rst_L at clear cycle 2, release -> o_Busy remains high for a full 4 cycles after release; all words read 0x0000.

Source files
------------

// File: rtl/ram_2port_be_clr.sv
// Simple dual-port RAM on one clock: one write port and one read port.
// Writes are masked per byte, and the read latency can be set to 1 or 2 cycles.
// The same-address read-during-write result can be old data or new data.
// A clear sequencer writes CLEAR_VALUE to every word after reset and whenever
// a clear is requested.
//
// Ports:
//   i_Clk      clock for both ports
//   i_Rst_L    asynchronous active-low reset; afterwards the array is cleared
//   i_Wr_*     write port: address, strobe, data, byte enables
//   i_Rd_*     read port: address, request
//   o_Rd_DV    one-cycle pulse per accepted read
//   o_Rd_Data  read data; holds its last value while o_Rd_DV is low
//   i_Clear    level-sampled request to clear the whole array
//   o_Busy     high while the clear sequencer owns the array
module ram_2port_be_clr #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      RD_LATENCY  = 1,
  parameter int unsigned      RDW_MODE    = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic [WIDTH/8-1:0]       i_Wr_Be,
  input  logic [$clog2(DEPTH)-1:0] i_Rd_Addr,
  input  logic                     i_Rd_En,
  output logic                     o_Rd_DV,
  output logic [WIDTH-1:0]         o_Rd_Data,
  input  logic                     i_Clear,
  output logic                     o_Busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic {StClear, StIdle} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            clr_last;

  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [NB-1:0]   mem_be;
  logic [WIDTH-1:0] mem_wdata;

  logic            rd_accept;
  logic            rd_in_range;
  logic [WIDTH-1:0] rd_word;

  logic            dv1_q;
  logic [WIDTH-1:0] data1_q;

  logic [WIDTH-1:0] mem [DEPTH];

  // The clear sequence ends on the write to the last word.
  assign clr_last = (32'(clr_addr_q) == DEPTH - 1);

  // FSM state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StClear: begin
        if (clr_last) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StIdle: begin
        // A clear request in StClear is ignored because it is only sampled here.
        if (i_Clear) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = StClear;
        clr_addr_d = '0;
      end
    endcase
  end

  // FSM outputs: busy flag and ownership of the array write port
  always_comb begin
    o_Busy    = (state_q == StClear);
    wr_ok     = i_Wr_DV && (state_q == StIdle) && (32'(i_Wr_Addr) < DEPTH);
    mem_we    = wr_ok;
    mem_addr  = i_Wr_Addr;
    mem_be    = i_Wr_Be;
    mem_wdata = i_Wr_Data;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr_q;
      mem_be    = '1;
      mem_wdata = CLEAR_VALUE;
    end
  end

  // Storage has no reset; the clear sequence initialises it.
  always_ff @(posedge i_Clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read word selection. Addresses beyond the array read as zero.
  assign rd_accept   = i_Rd_En && (state_q == StIdle);
  assign rd_in_range = (32'(i_Rd_Addr) < DEPTH);

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[i_Rd_Addr];
      // New-data mode: forward the enabled bytes of a same-address write.
      if ((RDW_MODE == 1) && wr_ok && (i_Wr_Addr == i_Rd_Addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (i_Wr_Be[b]) rd_word[b*8 +: 8] = i_Wr_Data[b*8 +: 8];
        end
      end
    end
  end

  // First read stage. Data only updates on accepted reads, so it holds otherwise.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      dv1_q   <= 1'b0;
      data1_q <= '0;
    end else begin
      dv1_q <= rd_accept;
      if (rd_accept) data1_q <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic             dv2_q;
    logic [WIDTH-1:0] data2_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        dv2_q   <= 1'b0;
        data2_q <= '0;
      end else begin
        dv2_q <= dv1_q;
        if (dv1_q) data2_q <= data1_q;
      end
    end

    assign o_Rd_DV   = dv2_q;
    assign o_Rd_Data = data2_q;
  end else begin : g_lat1
    assign o_Rd_DV   = dv1_q;
    assign o_Rd_Data = data1_q;
  end

endmodule

// File: tb/tb_ram_2port_be_clr.sv
module tb_ram_2port_be_clr;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_addr;
  logic        wr_dv;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [1:0]  rd_addr;
  logic        rd_en;
  logic        clr;

  logic        dv1, busy1;
  logic [15:0] data1;
  logic        dv2, busy2;
  logic [15:0] data2;

  int n_checks = 0;
  int n_fail   = 0;

  // dut1: latency 1, old data on read-during-write
  ram_2port_be_clr #(
    .WIDTH(16), .DEPTH(4), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_VALUE(16'h0000)
  ) dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Wr_Addr(wr_addr), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data), .i_Wr_Be(wr_be),
    .i_Rd_Addr(rd_addr), .i_Rd_En(rd_en),
    .o_Rd_DV(dv1), .o_Rd_Data(data1),
    .i_Clear(clr), .o_Busy(busy1)
  );

  // dut2: latency 2, new data on read-during-write
  ram_2port_be_clr #(
    .WIDTH(16), .DEPTH(4), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_VALUE(16'h0000)
  ) dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Wr_Addr(wr_addr), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data), .i_Wr_Be(wr_be),
    .i_Rd_Addr(rd_addr), .i_Rd_En(rd_en),
    .o_Rd_DV(dv2), .o_Rd_Data(data2),
    .i_Clear(clr), .o_Busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_dv = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_dv = 1'b0;
  endtask

  // Single read; dut1 answers after one edge, dut2 after two.
  task automatic do_read(input string tag, input logic [1:0] a,
                         input logic [15:0] e1, input logic [15:0] e2);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0; wr_dv = 1'b0;
    check({tag, " dv1"}, 32'(dv1), 32'd1);
    check({tag, " data1"}, 32'(data1), 32'(e1));
    step();
    check({tag, " dv1 pulse"}, 32'(dv1), 32'd0);
    check({tag, " dv2"}, 32'(dv2), 32'd1);
    check({tag, " data2"}, 32'(data2), 32'(e2));
  endtask

  // Edges until busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [15:0] vals [4];
  int nb;

  initial begin
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst_n = 1'b0; wr_addr = '0; wr_dv = 1'b0; wr_data = '0; wr_be = '0;
    rd_addr = '0; rd_en = 1'b0; clr = 1'b0;

    // 1. Reset values, then the post-reset clear
    #1;
    check("reset busy1", 32'(busy1), 32'd1);
    check("reset busy2", 32'(busy2), 32'd1);
    check("reset dv1", 32'(dv1), 32'd0);
    check("reset data1", 32'(data1), 32'd0);
    check("reset dv2", 32'(dv2), 32'd0);
    step(); step();
    rst_n = 1'b1;
    count_busy(nb);
    check("post-reset busy cycles", 32'(nb), 32'd4);
    check("busy2 low after clear", 32'(busy2), 32'd0);
    for (int i = 0; i < 4; i++) do_read("cleared read", 2'(i), 16'h0000, 16'h0000);

    // 2. Full-word writes then back-to-back reads
    for (int i = 0; i < 4; i++) wr(2'(i), vals[i], 2'b11);
    rd_en = 1'b1; rd_addr = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 4) rd_addr = 2'(k);
      else rd_en = 1'b0;
      check("b2b dv1", 32'(dv1), 32'(k <= 4));
      check("b2b dv2", 32'(dv2), 32'(k >= 2 && k <= 5));
      if (k <= 4) check("b2b data1", 32'(data1), 32'(vals[k-1]));
      if (k >= 2 && k <= 5) check("b2b data2", 32'(data2), 32'(vals[k-2]));
    end
    check("data1 holds", 32'(data1), 32'h4444);
    check("data2 holds", 32'(data2), 32'h4444);

    // 3. Byte enables
    wr(2'd1, 16'hAB55, 2'b01);
    do_read("be low", 2'd1, 16'h2255, 16'h2255);
    wr(2'd1, 16'hCD00, 2'b10);
    do_read("be high", 2'd1, 16'hCD55, 16'hCD55);
    wr(2'd1, 16'hFFFF, 2'b00);
    do_read("be none", 2'd1, 16'hCD55, 16'hCD55);

    // 4. Same-address read during write
    wr(2'd1, 16'h2222, 2'b11);
    wr_dv = 1'b1; wr_addr = 2'd1; wr_data = 16'h0054; wr_be = 2'b11;
    do_read("rdw full", 2'd1, 16'h2222, 16'h0054);
    do_read("after rdw", 2'd1, 16'h0054, 16'h0054);
    wr_dv = 1'b1; wr_addr = 2'd2; wr_data = 16'hAB55; wr_be = 2'b01;
    do_read("rdw merged", 2'd2, 16'h3333, 16'h3355);
    do_read("after merged", 2'd2, 16'h3355, 16'h3355);

    // 5. Clear request with writes and reads held active
    clr = 1'b1;
    wr_dv = 1'b1; wr_addr = 2'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 2'd2;
    for (int k = 0; k <= 4; k++) begin
      step();
      if (k == 2) clr = 1'b0;
      check("clr busy", 32'(busy1), 32'(k < 4));
      check("clr dv1", 32'(dv1), 32'(k == 0));
      check("clr dv2", 32'(dv2), 32'(k == 1));
      if (k == 0) check("in-flight data1", 32'(data1), 32'h3355);
      if (k == 1) check("in-flight data2", 32'(data2), 32'h3355);
    end
    wr_dv = 1'b0; rd_en = 1'b0; clr = 1'b0;
    for (int i = 0; i < 4; i++) do_read("after clear", 2'(i), 16'h0000, 16'h0000);

    // 6. Reset in the middle of a clear
    wr(2'd0, 16'hA1A1, 2'b11);
    wr(2'd1, 16'hB2B2, 2'b11);
    wr(2'd2, 16'hC3C3, 2'b11);
    wr(2'd3, 16'hBEEF, 2'b11);
    do_read("pre-reset", 2'd3, 16'hBEEF, 16'hBEEF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clear started", 32'(busy1), 32'd1);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 32'(busy1), 32'd1);
    check("mid reset dv1", 32'(dv1), 32'd0);
    check("mid reset data1", 32'(data1), 32'd0);
    check("mid reset data2", 32'(data2), 32'd0);
    step(); step();
    rst_n = 1'b1;
    count_busy(nb);
    check("restart busy cycles", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) do_read("after reset clr", 2'(i), 16'h0000, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
